hilo_mult_scheduler: RTL and testbench

- Owns the HI/LO register pair and sequences every operation that uses it: mult/multu, madd, msub and mthi/mtlo writes.
- Uses an iterative shift-add multiplier, so a multiply occupies the unit for many cycles.
- Generates the pipeline stall that holds younger HI/LO readers (mfhi/mflo) and new HI/LO operations until the unit is free.
- Sits beside the EX stage and is driven by the decode-stage control signals Madd, Msub, HiLoWrite and HiOrLo.

---
 rtl/hilo_mult_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_hilo_mult_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mult_scheduler.sv
// hilo_mult_scheduler: owns the HI/LO register pair and sequences mult/multu,
// madd/msub and mthi/mtlo. Multiplies run on an iterative shift-add datapath
// retiring BITS_PER_CYCLE multiplier bits per cycle, then one accumulate cycle.
//
// Ports:
//   Clk, Rst_n        clock (rising edge), asynchronous active-low reset
//   Start             multiply-class op in EX this cycle
//   Signed            1 = signed operands, 0 = unsigned
//   Madd / Msub       accumulate into / subtract from HI:LO
//   OperandA/B        rs / rt values
//   HiLoWrite         mthi/mtlo in EX; HiOrLo selects HI (1) or LO (0)
//   WriteData         mthi/mtlo data
//   HiLoRead          mfhi/mflo in ID this cycle
//   Flush             kill the in-flight op
//   Hi / Lo           HI and LO registers
//   Busy              unit occupied (state != IDLE)
//   Done              one-cycle pulse, new HI/LO visible this cycle
//   Stall             combinational pipeline hold
module hilo_mult_scheduler #(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Start,
  input  logic        Signed,
  input  logic        Madd,
  input  logic        Msub,
  input  logic [31:0] OperandA,
  input  logic [31:0] OperandB,
  input  logic        HiLoWrite,
  input  logic        HiOrLo,
  input  logic [31:0] WriteData,
  input  logic        HiLoRead,
  input  logic        Flush,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        Busy,
  output logic        Done,
  output logic        Stall
);

  localparam int unsigned N        = 32 / BITS_PER_CYCLE;
  localparam int unsigned CNT_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ACC  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [63:0]      acc_q, acc_d;
  logic [63:0]      mcand_q, mcand_d;
  logic [31:0]      mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             madd_q, madd_d;
  logic             msub_q, msub_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic        accept_op;
  logic        accept_wr;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [63:0] step_sum;
  logic [63:0] product;
  logic [63:0] hilo_new;

  // New work is only taken in IDLE; Flush kills a same-cycle issue.
  assign accept_op = (state_q == S_IDLE) & Start & ~Flush;
  assign accept_wr = (state_q == S_IDLE) & HiLoWrite & ~Start & ~Flush;

  // Magnitudes for signed ops; -0x80000000 wraps to 0x80000000, which is the
  // correct unsigned magnitude 2^31.
  assign a_abs = (Signed & OperandA[31]) ? (~OperandA + 32'd1) : OperandA;
  assign b_abs = (Signed & OperandB[31]) ? (~OperandB + 32'd1) : OperandB;

  // Partial product for the BITS_PER_CYCLE low multiplier bits this cycle.
  always_comb begin
    step_sum = 64'd0;
    for (int j = 0; j < int'(BITS_PER_CYCLE); j++) begin
      if (mplier_q[j]) begin
        step_sum = step_sum + (mcand_q << j);
      end
    end
  end

  // Signed product and the accumulate/subtract result, modulo 2^64.
  always_comb begin
    product  = neg_q ? (~acc_q + 64'd1) : acc_q;
    hilo_new = product;
    if (madd_q) begin
      hilo_new = {hi_q, lo_q} + product;
    end else if (msub_q) begin
      hilo_new = {hi_q, lo_q} - product;
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept_op) begin
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (Flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ACC;
        end
      end
      S_ACC:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    madd_d   = madd_q;
    msub_d   = msub_q;
    done_d   = 1'b0;
    busy_d   = (state_d != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (accept_op) begin
          acc_d    = 64'd0;
          mcand_d  = {32'd0, a_abs};
          mplier_d = b_abs;
          cnt_d    = '0;
          neg_d    = Signed & (OperandA[31] ^ OperandB[31]);
          madd_d   = Madd;
          msub_d   = Msub;
        end else if (accept_wr) begin
          if (HiOrLo) begin
            hi_d = WriteData;
          end else begin
            lo_d = WriteData;
          end
        end
      end
      S_MUL: begin
        if (!Flush) begin
          acc_d    = acc_q + step_sum;
          mcand_d  = mcand_q << BITS_PER_CYCLE;
          mplier_d = mplier_q >> BITS_PER_CYCLE;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      S_ACC: begin
        if (!Flush) begin
          hi_d   = hilo_new[63:32];
          lo_d   = hilo_new[31:0];
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      acc_q    <= 64'd0;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      madd_q   <= 1'b0;
      msub_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      madd_q   <= madd_d;
      msub_q   <= msub_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Hi   = hi_q;
  assign Lo   = lo_q;
  assign Busy = busy_q;
  assign Done = done_q;

  // Readers wait behind any HI/LO producer in EX or in flight; producers wait
  // while the unit is occupied.
  assign Stall = (HiLoRead & (busy_q | Start | HiLoWrite)) |
                 ((Start | HiLoWrite) & busy_q);

endmodule

// File: tb/tb_hilo_mult_scheduler.sv
module tb_hilo_mult_scheduler;

  localparam int N1 = 32;
  localparam int N4 = 8;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Start, Signed, Madd, Msub, HiLoWrite, HiOrLo, HiLoRead, Flush;
  logic [31:0] OperandA, OperandB, WriteData;
  logic [31:0] Hi, Lo, Hi4, Lo4;
  logic        Busy, Done, Stall, Busy4, Done4, Stall4;

  int total = 0;
  int bad   = 0;
  logic [63:0] m_hilo;

  always #5 Clk = ~Clk;

  hilo_mult_scheduler dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Signed(Signed), .Madd(Madd),
    .Msub(Msub), .OperandA(OperandA), .OperandB(OperandB),
    .HiLoWrite(HiLoWrite), .HiOrLo(HiOrLo), .WriteData(WriteData),
    .HiLoRead(HiLoRead), .Flush(Flush), .Hi(Hi), .Lo(Lo), .Busy(Busy),
    .Done(Done), .Stall(Stall)
  );

  hilo_mult_scheduler #(.BITS_PER_CYCLE(4)) dut4 (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Signed(Signed), .Madd(Madd),
    .Msub(Msub), .OperandA(OperandA), .OperandB(OperandB),
    .HiLoWrite(HiLoWrite), .HiOrLo(HiOrLo), .WriteData(WriteData),
    .HiLoRead(HiLoRead), .Flush(Flush), .Hi(Hi4), .Lo(Lo4), .Busy(Busy4),
    .Done(Done4), .Stall(Stall4)
  );

  // Reference: full-width product, sign-extended operands, modulo 2^64.
  function automatic logic [63:0] ref_prod(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ae, be;
    ae = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    be = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    return ae * be;
  endfunction

  function automatic void model_op(input logic sgn, input logic md, input logic ms, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = ref_prod(sgn, a, b);
    if (md)      m_hilo = m_hilo + p;
    else if (ms) m_hilo = m_hilo - p;
    else         m_hilo = p;
  endfunction

  function automatic void model_wr(input logic hi_sel, input logic [31:0] d);
    if (hi_sel) m_hilo[63:32] = d;
    else        m_hilo[31:0]  = d;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Issues one multiply at cycle T and returns what was seen at T+N1+2.
  task automatic run_op(input logic sgn, input logic md, input logic ms,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic lat_ok, output logic done_o,
                        output logic busy_o, output logic [63:0] hilo_o);
    Start = 1'b1; Signed = sgn; Madd = md; Msub = ms; OperandA = a; OperandB = b;
    lat_ok = 1'b1;
    tick();
    Start = 1'b0; Madd = 1'b0; Msub = 1'b0;
    for (int c = 1; c <= N1 + 1; c++) begin
      if (Busy !== 1'b1 || Done !== 1'b0) lat_ok = 1'b0;
      tick();
    end
    done_o = Done;
    busy_o = Busy;
    hilo_o = {Hi, Lo};
  endtask

  task automatic hl_write(input logic hi_sel, input logic [31:0] d);
    HiLoWrite = 1'b1; HiOrLo = hi_sel; WriteData = d;
    tick();
    HiLoWrite = 1'b0;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    Start = 0; Signed = 0; Madd = 0; Msub = 0; HiLoWrite = 0; HiOrLo = 0;
    HiLoRead = 0; Flush = 0; OperandA = 0; OperandB = 0; WriteData = 0;
    tick(); tick();
    total++; if ({Hi, Lo} !== 64'd0) begin bad++; $display("FAIL reset_hilo: got %h want 0", {Hi, Lo}); end
    total++; if (Busy !== 1'b0 || Done !== 1'b0) begin bad++; $display("FAIL reset_flags: got busy=%b done=%b want 0 0", Busy, Done); end
    total++; if (Stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", Stall); end
    total++; if (Busy4 !== 1'b0 || {Hi4, Lo4} !== 64'd0) begin bad++; $display("FAIL reset_dut4: got busy=%b hilo=%h want 0", Busy4, {Hi4, Lo4}); end
    Rst_n = 1'b1;
    m_hilo = 64'd0;
    tick();
  endtask

  task automatic test_op(input string name, input logic sgn, input logic md, input logic ms,
                         input logic [31:0] a, input logic [31:0] b);
    logic ok, d, bz;
    logic [63:0] hl;
    run_op(sgn, md, ms, a, b, ok, d, bz, hl);
    model_op(sgn, md, ms, a, b);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL %s_latency: busy/done wrong during T+1..T+%0d", name, N1 + 1); end
    total++; if (d !== 1'b1 || bz !== 1'b0) begin bad++; $display("FAIL %s_done: got done=%b busy=%b want 1 0", name, d, bz); end
    total++; if (hl !== m_hilo) begin bad++; $display("FAIL %s_hilo: got %h want %h", name, hl, m_hilo); end
    tick();
    total++; if (Done !== 1'b0) begin bad++; $display("FAIL %s_pulse: got done=%b want 0", name, Done); end
  endtask

  task automatic test_write(input logic hi_sel, input logic [31:0] d);
    hl_write(hi_sel, d);
    model_wr(hi_sel, d);
    total++; if ({Hi, Lo} !== m_hilo || Done !== 1'b0) begin bad++; $display("FAIL hl_write: got %h done=%b want %h done=0", {Hi, Lo}, Done, m_hilo); end
  endtask

  task automatic test_madd_msub();
    test_write(1'b0, 32'h10);
    test_write(1'b1, 32'h0);
    test_op("madd", 1'b1, 1'b1, 1'b0, 32'd5, 32'd6);
    total++; if ({Hi, Lo} !== 64'h0000_0000_0000_002E) begin bad++; $display("FAIL madd_const: got %h want 2e", {Hi, Lo}); end
    test_write(1'b0, 32'h5);
    test_write(1'b1, 32'h0);
    test_op("msub", 1'b1, 1'b0, 1'b1, 32'd2, 32'd3);
    total++; if ({Hi, Lo} !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL msub_const: got %h want all ones", {Hi, Lo}); end
  endtask

  task automatic test_stall();
    logic ok;
    ok = 1'b1;
    HiLoRead = 1'b1;
    Start = 1'b1; Signed = 1'b0; OperandA = 32'h1234_5678; OperandB = 32'h9ABC_DEF0;
    #1;
    if (Stall !== 1'b1) ok = 1'b0;
    tick();
    Start = 1'b0;
    for (int c = 1; c <= N1 + 1; c++) begin
      if (Stall !== 1'b1) ok = 1'b0;
      tick();
    end
    model_op(1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL stall_hold: stall dropped during T..T+%0d", N1 + 1); end
    total++; if (Stall !== 1'b0) begin bad++; $display("FAIL stall_release: got %b want 0", Stall); end
    total++; if ({Hi, Lo} !== m_hilo) begin bad++; $display("FAIL stall_hilo: got %h want %h", {Hi, Lo}, m_hilo); end
    HiLoRead = 1'b0;
    tick();
  endtask

  // An mthi arriving mid-multiply must stall and must not be taken.
  task automatic test_busy_reject();
    logic ok;
    ok = 1'b1;
    Start = 1'b1; Signed = 1'b1; OperandA = 32'hFFFF_0001; OperandB = 32'd12345;
    tick();
    Start = 1'b0;
    for (int c = 1; c <= N1 + 1; c++) begin
      if (c == 5) begin
        HiLoWrite = 1'b1; HiOrLo = 1'b1; WriteData = 32'hDEAD_BEEF;
        #1;
        total++; if (Stall !== 1'b1) begin bad++; $display("FAIL reject_stall: got %b want 1", Stall); end
      end
      tick();
      HiLoWrite = 1'b0;
    end
    model_op(1'b1, 1'b0, 1'b0, 32'hFFFF_0001, 32'd12345);
    total++; if (Done !== 1'b1 || {Hi, Lo} !== m_hilo) begin bad++; $display("FAIL reject_hilo: got done=%b %h want 1 %h", Done, {Hi, Lo}, m_hilo); end
    tick();
  endtask

  task automatic test_random();
    int kind;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      kind = $urandom_range(0, 5);
      a = pick();
      b = pick();
      case (kind)
        0: test_op("rnd_mult", 1'b1, 1'b0, 1'b0, a, b);
        1: test_op("rnd_multu", 1'b0, 1'b0, 1'b0, a, b);
        2: test_op("rnd_madd", 1'($urandom_range(0, 1)), 1'b1, 1'b0, a, b);
        3: test_op("rnd_msub", 1'($urandom_range(0, 1)), 1'b0, 1'b1, a, b);
        4: test_write(1'b1, a);
        default: test_write(1'b0, a);
      endcase
    end
  endtask

  task automatic test_flush();
    logic ok;
    ok = 1'b1;
    Start = 1'b1; Signed = 1'b1; OperandA = 32'h1234_5678; OperandB = 32'd9;
    tick();
    Start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b want 0", Busy); end
    total++; if ({Hi, Lo} !== m_hilo) begin bad++; $display("FAIL flush_hilo: got %h want %h", {Hi, Lo}, m_hilo); end
    for (int c = 0; c < N1 + 4; c++) begin
      if (Done !== 1'b0 || {Hi, Lo} !== m_hilo) ok = 1'b0;
      tick();
    end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL flush_nodone: done or hilo changed after flush"); end
  endtask

  task automatic test_reset_mid();
    Start = 1'b1; Signed = 1'b0; OperandA = 32'h7; OperandB = 32'h9;
    tick();
    Start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    Rst_n = 1'b0;
    #1;
    total++; if ({Hi, Lo} !== 64'd0 || Busy !== 1'b0 || Done !== 1'b0) begin bad++; $display("FAIL reset_mid: got hilo=%h busy=%b done=%b want 0 0 0", {Hi, Lo}, Busy, Done); end
    tick();
    Rst_n = 1'b1;
    m_hilo = 64'd0;
    tick();
  endtask

  task automatic test_bpc4();
    logic ok;
    logic [63:0] p;
    ok = 1'b1;
    p = ref_prod(1'b1, 32'h8000_0000, 32'h8000_0000);
    Start = 1'b1; Signed = 1'b1; OperandA = 32'h8000_0000; OperandB = 32'h8000_0000;
    tick();
    Start = 1'b0;
    for (int c = 1; c <= N1 + 2; c++) begin
      if (c <= N4 + 1 && (Busy4 !== 1'b1 || Done4 !== 1'b0)) ok = 1'b0;
      if (c == N4 + 2) begin
        total++; if (Done4 !== 1'b1 || Busy4 !== 1'b0) begin bad++; $display("FAIL bpc4_done: got done=%b busy=%b want 1 0", Done4, Busy4); end
        total++; if ({Hi4, Lo4} !== p) begin bad++; $display("FAIL bpc4_hilo: got %h want %h", {Hi4, Lo4}, p); end
      end
      if (c < N1 + 2) tick();
    end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL bpc4_latency: busy/done wrong during T+1..T+%0d", N4 + 1); end
    total++; if (Done !== 1'b1 || {Hi, Lo} !== p) begin bad++; $display("FAIL min_sq_bpc1: got done=%b %h want 1 %h", Done, {Hi, Lo}, p); end
    total++; if (p !== 64'h4000_0000_0000_0000) begin bad++; $display("FAIL min_sq_ref: got %h want 4000000000000000", p); end
    tick();
  endtask

  initial begin
    test_reset();
    test_op("mult_7x-3", 1'b1, 1'b0, 1'b0, 32'd7, 32'hFFFF_FFFD);
    total++; if ({Hi, Lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin bad++; $display("FAIL mult_const: got %h want ffffffffffffffeb", {Hi, Lo}); end
    test_op("multu_max", 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    total++; if ({Hi, Lo} !== 64'hFFFF_FFFE_0000_0001) begin bad++; $display("FAIL multu_const: got %h want fffffffe00000001", {Hi, Lo}); end
    test_madd_msub();
    test_stall();
    test_busy_reject();
    test_op("zero_operand", 1'b1, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFF);
    test_random();
    test_flush();
    test_reset_mid();
    test_bpc4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
